pwm_core: RTL
=============

// Module: pwm_core
// PURPOSE
//  Pointwise (NTT-domain) modular multiplier for Dilithium polynomials, q=8380417, N=256.
//  Streams A[i] and B[i] from two sync-read RAMs and writes C[i] = A[i]*B[i] mod q.
//  C is the coefficient RAM that the INTT core then transforms; pwm_core sits directly upstream of it.
//  Fully pipelined: one coefficient per cycle, no stalls.
// PARAMETERS
//  WIDTH  24        coefficient width
//  Q      8380417   modulus
//  MU     33587228  floor(2^48/Q), Barrett constant
//  N      256       coefficients per polynomial (fixed; address width 8)
// PORTS
//  clk      in   1      clock
//  rst_n    in   1      asynchronous reset, active-low
//  start    in   1      begin one polynomial pass; sampled only in IDLE
//  busy     out  1      high from cycle after start accepted until done pulse
//  done     out  1      one-cycle pulse after last C write
//  rd_addr  out  8      shared read address to A and B RAMs
//  a_rdata  in   WIDTH  A RAM data, valid cycle after rd_addr
//  b_rdata  in   WIDTH  B RAM data, valid cycle after rd_addr
//  c_addr   out  8      C RAM write address
//  c_we     out  1      C RAM write enable
//  c_wdata  out  WIDTH  C RAM write data
//  acc      in   1      PWM_ACC_EN only: accumulate mode, latched at start
//  c_rdata  in   WIDTH  PWM_ACC_EN only: C RAM read data (read port addressed by rd_addr)
// BEHAVIOUR
//  - Reset: busy=0, done=0, rd_addr=0, c_addr=0, c_we=0, c_wdata=0, FSM=IDLE, pipeline valids cleared.
//  - FSM: IDLE -(start)-> ISSUE -(rd_addr==255 issued)-> DRAIN -(last write)-> DONE -> IDLE.
//  - start accepted at edge T: rd_addr=0..255 in cycles T+1..T+256, one per cycle, no gaps.
//  - Pipeline (LAT=5): rdata capture/product x=a*b (48b) | qh=(x*MU)>>48 | r=x-qh*Q |
//    corr: r>=2Q?r-2Q : r>=Q?r-Q : r | register c_we/c_addr/c_wdata.
//  - Write of index k asserted in cycle T+1+k+5; last write cycle T+261; done=1 in cycle T+262.
//  - Valid bit travels with each index; c_addr is the delayed rd_addr, never recomputed.
//  - Any 24-bit operands (incl. >=Q) yield exact (a*b) mod Q; r<3Q guaranteed, two compares suffice.
//  - c_wdata always in [0,Q-1].
//  - start while busy or in DONE: ignored. start held high: next pass begins only after return to IDLE.
//  - rd_addr wraps 255->0 only by starting a new pass; counter is 9 bits internally, terminal at 256.
//  - Reset mid-pass: immediate abort, all outputs to reset values, partial C contents undefined.
//  - c_we low in every cycle without a valid pipeline entry; c_wdata holds last value.
// CONFIGURATION
//  PWM_ACC_EN defined: ports acc, c_rdata exist; extra pipeline stage, LAT=6 (writes T+1+k+6,
//    done T+263) regardless of acc. C read at rd_addr alongside A/B, delayed to align with the result.
//    acc=1: c_wdata=(C_old[k]+A*B) mod Q via one conditional subtract. acc=0: plain product.
//    C read/write address collision impossible (read k+LAT ahead of write k).
//  PWM_ACC_EN undefined: ports absent, LAT=5 as above.
// TESTING
//  1. A[i]=i, B[i]=1 -> C[i]=i for all i; done exactly T+262; 256 writes, no gaps.
//  2. A[i]=B[i]=Q-1 -> C[i]=1 for all i.
//  3. A[i]=B[i]=16777215 (out of range) -> C[i]=163817.
//  4. A[0]=2,B[0]=4190209 -> C[0]=1; A[255]=3,B[255]=0 -> C[255]=0; boundary addresses written.
//  5. rst_n low at T+100, then restart -> outputs reset same cycle; clean full pass after; start pulses while busy ignored.
//  6. PWM_ACC_EN, acc=1, C_old[i]=Q-1, A[i]=1, B[i]=1 -> C[i]=0; acc=0 -> C[i]=1; done at T+263.

Source files
------------

// File: rtl/pwm_core_if.sv
// Bus bundle for pwm_core: control handshake plus A/B/C RAM ports.
// PWM_ACC_EN adds the accumulate-mode acc and c_rdata signals.
interface pwm_core_if #(
  parameter int WIDTH = 24
);
  logic             start;
  logic             busy;
  logic             done;
  logic [7:0]       rd_addr;
  logic [WIDTH-1:0] a_rdata;
  logic [WIDTH-1:0] b_rdata;
  logic [7:0]       c_addr;
  logic             c_we;
  logic [WIDTH-1:0] c_wdata;
`ifdef PWM_ACC_EN
  logic             acc;
  logic [WIDTH-1:0] c_rdata;
`endif

  modport master (
    output start,
    output a_rdata,
    output b_rdata,
`ifdef PWM_ACC_EN
    output acc,
    output c_rdata,
`endif
    input  busy,
    input  done,
    input  rd_addr,
    input  c_addr,
    input  c_we,
    input  c_wdata
  );

  modport slave (
    input  start,
    input  a_rdata,
    input  b_rdata,
`ifdef PWM_ACC_EN
    input  acc,
    input  c_rdata,
`endif
    output busy,
    output done,
    output rd_addr,
    output c_addr,
    output c_we,
    output c_wdata
  );
endinterface

// File: rtl/pwm_core.sv
// Pointwise NTT-domain multiplier C[i]=A[i]*B[i] mod q, Barrett reduced.
// PWM_ACC_EN: adds accumulate mode C[i]=(C_old[i]+A[i]*B[i]) mod q.
module pwm_core #(
  parameter int WIDTH = 24,
  parameter int Q     = 8380417,
  parameter int MU    = 33587228
) (
  input logic       clk,
  input logic       rst_n,
  pwm_core_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

`ifdef PWM_ACC_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif
  localparam int NV = LAT - 1;

  localparam logic [25:0] Q1 = 26'(Q);
  localparam logic [25:0] Q2 = 26'(2 * Q);

  logic [1:0]       st_q, st_d;
  logic [8:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [NV-1:0]    vld_q, vld_d;
  logic [7:0]       adr_q [NV];
  logic [7:0]       adr_d [NV];
  logic [47:0]      x_q, x_d;
  logic [47:0]      x2_q, x2_d;
  logic [25:0]      qh_q, qh_d;
  logic [25:0]      r_q, r_d;
  logic             c_we_q, c_we_d;
  logic [7:0]       c_addr_q, c_addr_d;
  logic [WIDTH-1:0] c_wdata_q, c_wdata_d;

  logic [73:0]      prod;
  logic [47:0]      rfull;
  logic [25:0]      rc;
  logic [WIDTH-1:0] p_d;
  logic [WIDTH-1:0] fin;
  logic [7:0]       rd_addr;
  logic             issue;

`ifdef PWM_ACC_EN
  logic             acc_q, acc_d;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] c1_q, c1_d, c2_q, c2_d;
  logic [WIDTH-1:0] c3_q, c3_d, c4_q, c4_d;
  logic [WIDTH:0]   s, sm;
  logic             unused_bits;
  assign unused_bits = ^{rfull[47:26], prod[47:0], rc[25:24], sm[WIDTH]};
`else
  logic             unused_bits;
  assign unused_bits = ^{rfull[47:26], prod[47:0], rc[25:24]};
`endif

  // counter parks at 256 after the pass; the address holds 255 until restart
  assign rd_addr = cnt_q[8] ? 8'hff : cnt_q[7:0];
  assign issue   = (st_q == S_ISSUE);

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = done_q;
`ifdef PWM_ACC_EN
    acc_d  = acc_q;
`endif
    unique case (1'b1)
      (st_q == S_IDLE): begin
        if (bus.start) begin
          st_d   = S_ISSUE;
          cnt_d  = 9'd0;
          busy_d = 1'b1;
`ifdef PWM_ACC_EN
          acc_d  = bus.acc;
`endif
        end
      end
      (st_q == S_ISSUE): begin
        cnt_d = cnt_q + 9'd1;
        if (cnt_q == 9'd255) st_d = S_DRAIN;
      end
      (st_q == S_DRAIN): begin
        if (c_we_q && c_addr_q == 8'hff) begin
          st_d   = S_DONE;
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      (st_q == S_DONE): begin
        st_d   = S_IDLE;
        done_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    vld_d    = {vld_q[NV-2:0], issue};
    adr_d[0] = rd_addr;
    for (int i = 1; i < NV; i++) adr_d[i] = adr_q[i-1];

    x_d   = {24'd0, bus.a_rdata} * {24'd0, bus.b_rdata};
    x2_d  = x_q;
    prod  = {26'd0, x_q} * 74'(MU);
    qh_d  = prod[73:48];
    rfull = x2_q - ({22'd0, qh_q} * 48'(Q));
    r_d   = rfull[25:0];

    // Barrett leaves r < 3q, so two conditional subtracts finish it
    if (r_q >= Q2)      rc = r_q - Q2;
    else if (r_q >= Q1) rc = r_q - Q1;
    else                rc = r_q;
    p_d = rc[WIDTH-1:0];

`ifdef PWM_ACC_EN
    c1_d = bus.c_rdata;
    c2_d = c1_q;
    c3_d = c2_q;
    c4_d = c3_q;
    s    = {1'b0, p_q} + {1'b0, c4_q};
    sm   = (s >= (WIDTH+1)'(Q)) ? s - (WIDTH+1)'(Q) : s;
    fin  = acc_q ? sm[WIDTH-1:0] : p_q;
`else
    fin  = p_d;
`endif

    c_we_d    = vld_q[NV-1];
    c_addr_d  = c_addr_q;
    c_wdata_d = c_wdata_q;
    if (vld_q[NV-1]) begin
      c_addr_d  = adr_q[NV-1];
      c_wdata_d = fin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      vld_q     <= '0;
      for (int i = 0; i < NV; i++) adr_q[i] <= '0;
      x_q       <= '0;
      x2_q      <= '0;
      qh_q      <= '0;
      r_q       <= '0;
      c_we_q    <= 1'b0;
      c_addr_q  <= '0;
      c_wdata_q <= '0;
`ifdef PWM_ACC_EN
      acc_q     <= 1'b0;
      p_q       <= '0;
      c1_q      <= '0;
      c2_q      <= '0;
      c3_q      <= '0;
      c4_q      <= '0;
`endif
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      vld_q     <= vld_d;
      for (int i = 0; i < NV; i++) adr_q[i] <= adr_d[i];
      x_q       <= x_d;
      x2_q      <= x2_d;
      qh_q      <= qh_d;
      r_q       <= r_d;
      c_we_q    <= c_we_d;
      c_addr_q  <= c_addr_d;
      c_wdata_q <= c_wdata_d;
`ifdef PWM_ACC_EN
      acc_q     <= acc_d;
      p_q       <= p_d;
      c1_q      <= c1_d;
      c2_q      <= c2_d;
      c3_q      <= c3_d;
      c4_q      <= c4_d;
`endif
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_addr = rd_addr;
  assign bus.c_addr  = c_addr_q;
  assign bus.c_we    = c_we_q;
  assign bus.c_wdata = c_wdata_q;

endmodule
